alu_datapath_pipe: RTL and testbench
====================================

Name: alu_datapath_pipe

Overview:
Parametrised successor to the single-cycle register-file/operand-mux/ALU datapath.
- Adds an 8-operation ALU and a registered EX→WB pipeline stage with hazard handling.
- Adds a valid/ready instruction handshake and synchronous reset.
- Sits between the control unit/sign-extend (upstream) and branch logic/test harness (downstream via EQ, result, a0).

Parameters:
- XLEN, 32: datapath width in bits.
- NREGS, 32: number of architectural registers; power of two, >= 16. AW = $clog2(NREGS).
- A0_IDX, 10: register index exported on a0.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction present this cycle
- in_ready  out  1  datapath can accept instruction
- AD1  in  AW  read address 1 (rs1)
- AD2  in  AW  read address 2 (rs2)
- AD3  in  AW  write address (rd)
- WE3  in  1  register write enable
- ALUSrc  in  1  1: operand B = ImmOp; 0: operand B = rs2 value
- ALUCtrl  in  3  ALU operation select
- ImmOp  in  XLEN  sign-extended immediate
- out_valid  out  1  result/EQ valid
- result  out  XLEN  registered ALU result
- EQ  out  1  registered equality flag
- a0  out  XLEN  current contents of register A0_IDX

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high.
- Reset: all registers, wb_valid, out_valid, result, EQ and a0 go to 0. A pending writeback is discarded.
- Accept: an instruction is accepted when in_valid & in_ready at a rising edge.
- EX (combinational, accept cycle):
  - opA = rs1 value.
  - opB = ALUSrc ? ImmOp : rs2 value.
  - ALU computes on opA/opB.
- WB register (loaded at the accept edge): wb_valid=1, wb_we=WE3, wb_rd=AD3, wb_data=ALU result; result<=ALU result, EQ<=(opA==opB), out_valid<=1.
- Bubble: an edge with no accept clears wb_valid and out_valid. result/EQ hold their last values.
- Register write: at the edge after acceptance, if wb_valid & wb_we & wb_rd!=0, reg[wb_rd]<=wb_data.
- Latency:
  - result, EQ and out_valid appear 1 cycle after accept.
  - The architectural register (and a0) updates 1 cycle later than that (2 cycles after accept).
- Register 0: reads as 0; writes to register 0 are ignored; never forwarded.
- ALUCtrl:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor.
  - 5 slt (signed, result 1/0 zero-extended).
  - 6 sll, 7 srl; shift amount = opB[$clog2(XLEN)-1:0].
  - Arithmetic wraps modulo 2^XLEN.
- Hazard: the EX instruction reads AD1 (or AD2 with ALUSrc=0) equal to wb_rd, with wb_valid & wb_we & wb_rd!=0. Handling depends on the optional feature below.
- Both operands hazard: each operand is resolved independently.
- in_ready: 1 whenever no stall is required. It is 0 during reset.
- a0: combinational view of reg[A0_IDX]. It does not show forwarded values.

Optional Feature:
- Macro: ALU_DATAPATH_FWD_EN.
- Defined: hazarded operands take wb_data (bypass). in_ready stays 1 outside reset, and back-to-back dependent instructions issue every cycle.
- Undefined: no bypass. On a hazard in_ready=0 for exactly one cycle while WB commits. The upstream instruction is held and is accepted on the next cycle, reading the committed value.

Test Plan:
- Reset, then in_valid=0 → result=0, EQ=0, out_valid=0, a0=0, in_ready=1.
- Instruction addi x10,x0,5 (ALUSrc=1, ALUCtrl=0, ImmOp=5, WE3=1, AD3=10) → next cycle result=5, out_valid=1; following cycle a0=5.
- Back-to-back: addi x1,x0,7, then add x2,x1,x1.
  - FWD_EN defined: second instruction accepted immediately; result=14.
  - FWD_EN undefined: one cycle of in_ready=0, then result=14.
- Ops check with x1=0xFFFFFFF0 and x2=4:
  - sub gives 0xFFFFFFEC; slt gives 1.
  - sll gives 0xFFFFFF00; srl gives 0x0FFFFFFF.
  - xor gives 0xFFFFFFF4.
- Write to x0: addi x0,x0,9, then add x3,x0,x0 → result=0, EQ=1; no forwarding of 9.
- Reset mid-operation: assert rst on the edge where addi x10,x0,3 would commit → a0 stays 0, out_valid=0 after reset.

Source files
------------

// File: rtl/alu_datapath_pipe.sv
// ---------------------------------------------------------------------------
// alu_datapath_pipe
//
// Purpose:
//   Register file, operand mux and 8-operation ALU followed by a registered
//   EX->WB stage. Instructions arrive over a valid/ready handshake. The ALU
//   result and equality flag are registered and appear one cycle after
//   accept. The architectural register write commits one cycle after that.
//
// Configuration macro:
//   ALU_DATAPATH_FWD_EN - when defined, an operand that depends on the
//   pending writeback takes wb_data directly (bypass), and in_ready stays
//   high outside reset. When undefined, such a dependency holds in_ready
//   low for one cycle while the writeback commits. The upstream stage keeps
//   the instruction, and it is accepted on the next cycle with the
//   committed value.
//
// Ports:
//   clk       in   1     clock, rising edge
//   rst       in   1     synchronous active-high reset
//   in_valid  in   1     instruction present this cycle
//   in_ready  out  1     datapath can accept an instruction
//   AD1       in   AW    rs1 read address
//   AD2       in   AW    rs2 read address
//   AD3       in   AW    rd write address
//   WE3       in   1     register write enable
//   ALUSrc    in   1     1: operand B = ImmOp, 0: operand B = rs2 value
//   ALUCtrl   in   3     0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sll,7 srl
//   ImmOp     in   XLEN  sign-extended immediate
//   out_valid out  1     result/EQ valid
//   result    out  XLEN  registered ALU result
//   EQ        out  1     registered (opA == opB)
//   a0        out  XLEN  committed contents of register A0_IDX
// ---------------------------------------------------------------------------
module alu_datapath_pipe #(
   parameter int  XLEN   = 32,
   parameter int  NREGS  = 32,
   parameter int  A0_IDX = 10,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   AD1,
   input  logic [AW-1:0]   AD2,
   input  logic [AW-1:0]   AD3,
   input  logic            WE3,
   input  logic            ALUSrc,
   input  logic [2:0]      ALUCtrl,
   input  logic [XLEN-1:0] ImmOp,
   output logic            out_valid,
   output logic [XLEN-1:0] result,
   output logic            EQ,
   output logic [XLEN-1:0] a0
);

   localparam int SHW = $clog2(XLEN);

   // ALU operation. slt is signed. Shifts use the low SHW bits of operand B.
   function automatic logic [XLEN-1:0] alu_f(input logic [2:0]      ctrl,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
      logic [SHW-1:0] sh;
      sh = b[SHW-1:0];
      case (ctrl)
         3'd0:    alu_f = a + b;
         3'd1:    alu_f = a - b;
         3'd2:    alu_f = a & b;
         3'd3:    alu_f = a | b;
         3'd4:    alu_f = a ^ b;
         3'd5:    alu_f = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         3'd6:    alu_f = a << sh;
         3'd7:    alu_f = a >> sh;
         default: alu_f = '0;
      endcase
   endfunction

   logic [XLEN-1:0] regs_r [NREGS];
   logic            wb_valid_r;
   logic            wb_we_r;
   logic [AW-1:0]   wb_rd_r;
   logic [XLEN-1:0] wb_data_r;
   logic [XLEN-1:0] result_r;
   logic            eq_r;
   logic            out_valid_r;

   logic            wb_commit_s;
   logic            hz1_s;
   logic            hz2_s;
   logic            stall_s;
   logic            in_ready_s;
   logic            accept_s;
   logic [XLEN-1:0] rf_rd1_s;
   logic [XLEN-1:0] rf_rd2_s;
   logic [XLEN-1:0] rs1_val_s;
   logic [XLEN-1:0] rs2_val_s;
   logic [XLEN-1:0] op_a_s;
   logic [XLEN-1:0] op_b_s;
   logic [XLEN-1:0] alu_res_s;

   // A pending writeback to x0 never commits, so it never causes a hazard.
   assign wb_commit_s = wb_valid_r & wb_we_r & (wb_rd_r != '0);
   assign hz1_s       = wb_commit_s & (AD1 == wb_rd_r);
   assign hz2_s       = wb_commit_s & ~ALUSrc & (AD2 == wb_rd_r);

   // Register file read ports with x0 hard-wired to zero.
   always_comb begin
      rf_rd1_s = '0;
      rf_rd2_s = '0;
      if (AD1 == '0) begin
         rf_rd1_s = '0;
      end else begin
         rf_rd1_s = regs_r[AD1];
      end
      if (AD2 == '0) begin
         rf_rd2_s = '0;
      end else begin
         rf_rd2_s = regs_r[AD2];
      end
   end

   // Hazard resolution: bypass from WB, or stall until WB commits.
   always_comb begin
      rs1_val_s = rf_rd1_s;
      rs2_val_s = rf_rd2_s;
      stall_s   = 1'b0;
`ifdef ALU_DATAPATH_FWD_EN
      if (hz1_s) begin
         rs1_val_s = wb_data_r;
      end else begin
         rs1_val_s = rf_rd1_s;
      end
      if (hz2_s) begin
         rs2_val_s = wb_data_r;
      end else begin
         rs2_val_s = rf_rd2_s;
      end
`else
      stall_s = hz1_s | hz2_s;
`endif
   end

   // Operand B selection and ALU evaluation.
   always_comb begin
      op_a_s = rs1_val_s;
      if (ALUSrc) begin
         op_b_s = ImmOp;
      end else begin
         op_b_s = rs2_val_s;
      end
      alu_res_s = alu_f(ALUCtrl, op_a_s, op_b_s);
   end

   assign in_ready_s = ~rst & ~stall_s;
   assign accept_s   = in_valid & in_ready_s;

   // Architectural register file. Reset also drops any pending writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wb_commit_s) begin
         regs_r[wb_rd_r] <= wb_data_r;
      end
   end

   // EX->WB pipeline register and registered outputs. Bubbles keep result/EQ.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_r  <= 1'b0;
         wb_we_r     <= 1'b0;
         wb_rd_r     <= '0;
         wb_data_r   <= '0;
         result_r    <= '0;
         eq_r        <= 1'b0;
         out_valid_r <= 1'b0;
      end else if (accept_s) begin
         wb_valid_r  <= 1'b1;
         wb_we_r     <= WE3;
         wb_rd_r     <= AD3;
         wb_data_r   <= alu_res_s;
         result_r    <= alu_res_s;
         eq_r        <= (op_a_s == op_b_s);
         out_valid_r <= 1'b1;
      end else begin
         wb_valid_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign EQ        = eq_r;
   assign a0        = regs_r[A0_IDX];

endmodule

// File: tb/tb_alu_datapath_pipe.sv
// Directed testbench for alu_datapath_pipe (XLEN=32, NREGS=32, A0_IDX=10).
module tb_alu_datapath_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  AD1;
   logic [4:0]  AD2;
   logic [4:0]  AD3;
   logic        WE3;
   logic        ALUSrc;
   logic [2:0]  ALUCtrl;
   logic [31:0] ImmOp;
   logic        out_valid;
   logic [31:0] result;
   logic        EQ;
   logic [31:0] a0;

   int n_checks = 0;
   int n_fail   = 0;

   alu_datapath_pipe #(.XLEN(32), .NREGS(32), .A0_IDX(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .ALUSrc(ALUSrc),
      .ALUCtrl(ALUCtrl), .ImmOp(ImmOp), .out_valid(out_valid),
      .result(result), .EQ(EQ), .a0(a0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input logic we, input logic src,
                        input logic [2:0] ctrl, input logic [31:0] imm);
      in_valid = v; AD1 = a1; AD2 = a2; AD3 = a3;
      WE3 = we; ALUSrc = src; ALUCtrl = ctrl; ImmOp = imm;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      step();
      step();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
      rst = 1'b0;
      #1;
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
      n_checks++; if (EQ !== 1'b0) begin n_fail++; $display("FAIL reset_eq: got %b want 0", EQ); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (a0 !== 32'd0) begin n_fail++; $display("FAIL reset_a0: got %h want 0", a0); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      step();
   endtask

   task automatic test_addi_a0();
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 3'd0, 32'd5);
      step();
      idle();
      n_checks++; if (result !== 32'd5) begin n_fail++; $display("FAIL addi_result: got %h want 5", result); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_out_valid: got %b want 1", out_valid); end
      n_checks++; if (EQ !== 1'b0) begin n_fail++; $display("FAIL addi_eq: got %b want 0", EQ); end
      n_checks++; if (a0 !== 32'd0) begin n_fail++; $display("FAIL addi_a0_early: got %h want 0", a0); end
      step();
      n_checks++; if (a0 !== 32'd5) begin n_fail++; $display("FAIL addi_a0: got %h want 5", a0); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_bubble_valid: got %b want 0", out_valid); end
      n_checks++; if (result !== 32'd5) begin n_fail++; $display("FAIL addi_result_hold: got %h want 5", result); end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 3'd0, 32'd7);
      step();
      n_checks++; if (result !== 32'd7) begin n_fail++; $display("FAIL b2b_first: got %h want 7", result); end
      drive(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 3'd0, 32'd0);
      #1;
`ifdef ALU_DATAPATH_FWD_EN
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_fwd: got %b want 1", in_ready); end
      step();
`else
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b want 0", in_ready); end
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_valid: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_release: got %b want 1", in_ready); end
      step();
`endif
      idle();
      n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL b2b_result: got %h want 14", result); end
      n_checks++; if (EQ !== 1'b1) begin n_fail++; $display("FAIL b2b_eq: got %b want 1", EQ); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
      step();
      step();
   endtask

   task automatic test_ops();
      logic [31:0] exp_v [9];
      logic [2:0]  ctl_v [9];
      exp_v[0] = 32'hFFFFFFEC; ctl_v[0] = 3'd1;
      exp_v[1] = 32'h00000001; ctl_v[1] = 3'd5;
      exp_v[2] = 32'hFFFFFF00; ctl_v[2] = 3'd6;
      exp_v[3] = 32'h0FFFFFFF; ctl_v[3] = 3'd7;
      exp_v[4] = 32'hFFFFFFF4; ctl_v[4] = 3'd4;
      exp_v[5] = 32'hFFFFFFF4; ctl_v[5] = 3'd0;
      exp_v[6] = 32'h00000000; ctl_v[6] = 3'd2;
      exp_v[7] = 32'hFFFFFFF4; ctl_v[7] = 3'd3;
      exp_v[8] = 32'h00000000; ctl_v[8] = 3'd5;
      drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 3'd0, 32'hFFFFFFF0);
      step();
      drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 3'd0, 32'd4);
      step();
      idle();
      step();
      step();
      for (int i = 0; i < 9; i++) begin
         // The last entry swaps the operands: 4 < -16 is false when compared as signed.
         if (i == 8) drive(1'b1, 5'd2, 5'd1, 5'd5, 1'b0, 1'b0, ctl_v[i], 32'd0);
         else        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, ctl_v[i], 32'd0);
         step();
         n_checks++; if (result !== exp_v[i]) begin n_fail++; $display("FAIL ops_%0d ctrl=%0d: got %h want %h", i, ctl_v[i], result, exp_v[i]); end
      end
      drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 3'd0, 32'h00000010);
      step();
      idle();
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL ops_add_wrap: got %h want 0", result); end
      step();
   endtask

   task automatic test_x0();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 3'd0, 32'd9);
      step();
      n_checks++; if (result !== 32'd9) begin n_fail++; $display("FAIL x0_addi: got %h want 9", result); end
      drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 3'd0, 32'd0);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_no_hazard: got %b want 1", in_ready); end
      step();
      idle();
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL x0_add: got %h want 0", result); end
      n_checks++; if (EQ !== 1'b1) begin n_fail++; $display("FAIL x0_eq: got %b want 1", EQ); end
      step();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 3'd0, 32'd3);
      step();
      n_checks++; if (result !== 32'd3) begin n_fail++; $display("FAIL mid_result: got %h want 3", result); end
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      n_checks++; if (a0 !== 32'd0) begin n_fail++; $display("FAIL mid_a0: got %h want 0", a0); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL mid_result_clr: got %h want 0", result); end
      step();
      n_checks++; if (a0 !== 32'd0) begin n_fail++; $display("FAIL mid_a0_later: got %h want 0", a0); end
   endtask

   initial begin
      test_reset();
      test_addi_a0();
      test_back_to_back();
      test_ops();
      test_x0();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
